// File: rtl/intp_apb_host.sv
// Processor-side agent for the interrupt controller: APB initiator for priority programming
// plus the consumer end of the intp_valid / serviced handshake with a fixed-length service window.
module intp_apb_host #(
   parameter int NUM_OF_PERIPHERALS = 16,
   parameter int ADDR_WIDTH         = 4,
   parameter int DATA_WIDTH         = 4,
   parameter int SERVICE_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES     = 8
) (
   input  logic                          pclk_i,
   input  logic                          prst_n_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic                          cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]         cmd_wdata_i,
   output logic                          rsp_valid_o,
   output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
   output logic                          rsp_error_o,
   output logic                          psel_o,
   output logic                          penable_o,
   output logic                          pwrite_o,
   output logic [ADDR_WIDTH-1:0]         paddr_o,
   output logic [DATA_WIDTH-1:0]         pwdata_o,
   input  logic [DATA_WIDTH-1:0]         prdata_i,
   input  logic                          pready_i,
   input  logic                          perror_i,
   input  logic                          intp_valid_i,
   input  logic [ADDR_WIDTH-1:0]         intp_to_service_i,
   output logic                          intp_serviced_o,
   output logic [NUM_OF_PERIPHERALS-1:0] intp_clear_o,
   output logic                          busy_o,
   output logic [7:0]                    serviced_cnt_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(SERVICE_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SVC_LOAD = SW'(SERVICE_CYCLES);
   localparam logic [NUM_OF_PERIPHERALS-1:0] ONE_HOT_0 = {{(NUM_OF_PERIPHERALS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} a_state_t;
   typedef enum logic [1:0] {I_IDLE, I_SERVICE, I_DONE, I_DROP} i_state_t;

   a_state_t                      a_state_q, a_state_d;
   logic                          cmd_ready_q, cmd_ready_d;
   logic                          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]         paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]         pwdata_q, pwdata_d;
   logic [TW-1:0]                 tmo_cnt_q, tmo_cnt_d;
   logic                          rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
   logic [DATA_WIDTH-1:0]         rsp_rdata_q, rsp_rdata_d;

   i_state_t                      i_state_q, i_state_d;
   logic [ADDR_WIDTH-1:0]         id_q, id_d;
   logic [SW-1:0]                 svc_cnt_q, svc_cnt_d;
   logic                          serviced_q, serviced_d, busy_q, busy_d;
   logic [NUM_OF_PERIPHERALS-1:0] clear_q, clear_d;
   logic [7:0]                    serviced_cnt_q, serviced_cnt_d;

   always_comb begin
      a_state_d   = a_state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      tmo_cnt_d   = tmo_cnt_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (a_state_q)
         A_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               pwrite_d  = cmd_write_i;
               paddr_d   = cmd_addr_i;
               pwdata_d  = cmd_wdata_i;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               tmo_cnt_d = '0;
               a_state_d = A_SETUP;
            end
         end
         A_SETUP: begin
            penable_d = 1'b1;
            a_state_d = A_ACCESS;
         end
         A_ACCESS: begin
            if (pready_i) begin
               if (!pwrite_q) rsp_rdata_d = prdata_i;
               rsp_error_d = perror_i;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               a_state_d   = A_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               // Timeout: terminate without touching the held read data.
               rsp_error_d = 1'b1;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               a_state_d   = A_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         default: a_state_d = A_IDLE;
      endcase
      cmd_ready_d = (a_state_d == A_IDLE);
   end

   always_comb begin
      i_state_d      = i_state_q;
      id_d           = id_q;
      svc_cnt_d      = svc_cnt_q;
      serviced_d     = 1'b0;
      clear_d        = '0;
      serviced_cnt_d = serviced_cnt_q;
      case (i_state_q)
         I_IDLE: begin
            if (intp_valid_i) begin
               id_d      = intp_to_service_i;
               svc_cnt_d = SVC_LOAD;
               i_state_d = I_SERVICE;
            end
         end
         I_SERVICE: begin
            if (svc_cnt_q == SW'(1)) begin
               serviced_d     = 1'b1;
               clear_d        = ONE_HOT_0 << id_q;
               serviced_cnt_d = serviced_cnt_q + 8'd1;
               i_state_d      = I_DONE;
            end else begin
               svc_cnt_d = svc_cnt_q - SW'(1);
            end
         end
         I_DONE: i_state_d = I_DROP;
         // Valid must be seen low here so a stale request is never serviced twice.
         I_DROP: if (!intp_valid_i) i_state_d = I_IDLE;
         default: i_state_d = I_IDLE;
      endcase
      busy_d = (i_state_d != I_IDLE);
   end

   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         a_state_q      <= A_IDLE;
         cmd_ready_q    <= 1'b0;
         psel_q         <= 1'b0;
         penable_q      <= 1'b0;
         pwrite_q       <= 1'b0;
         paddr_q        <= '0;
         pwdata_q       <= '0;
         tmo_cnt_q      <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_error_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         i_state_q      <= I_IDLE;
         id_q           <= '0;
         svc_cnt_q      <= '0;
         serviced_q     <= 1'b0;
         clear_q        <= '0;
         busy_q         <= 1'b0;
         serviced_cnt_q <= 8'd0;
      end else begin
         a_state_q      <= a_state_d;
         cmd_ready_q    <= cmd_ready_d;
         psel_q         <= psel_d;
         penable_q      <= penable_d;
         pwrite_q       <= pwrite_d;
         paddr_q        <= paddr_d;
         pwdata_q       <= pwdata_d;
         tmo_cnt_q      <= tmo_cnt_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_error_q    <= rsp_error_d;
         rsp_rdata_q    <= rsp_rdata_d;
         i_state_q      <= i_state_d;
         id_q           <= id_d;
         svc_cnt_q      <= svc_cnt_d;
         serviced_q     <= serviced_d;
         clear_q        <= clear_d;
         busy_q         <= busy_d;
         serviced_cnt_q <= serviced_cnt_d;
      end
   end

   assign cmd_ready_o     = cmd_ready_q;
   assign psel_o          = psel_q;
   assign penable_o       = penable_q;
   assign pwrite_o        = pwrite_q;
   assign paddr_o         = paddr_q;
   assign pwdata_o        = pwdata_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_error_o     = rsp_error_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign intp_serviced_o = serviced_q;
   assign intp_clear_o    = clear_q;
   assign busy_o          = busy_q;
   assign serviced_cnt_o  = serviced_cnt_q;

endmodule

// File: tb/tb_intp_apb_host.sv
// Directed bench for intp_apb_host: APB transfers (zero/multi wait, timeout, error),
// interrupt service handshake, stale-valid handling, async reset and counter wrap.
module tb_intp_apb_host;

   logic        clk = 1'b0;
   logic        prst_n_i;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [3:0]  cmd_addr_i, cmd_wdata_i;
   logic        rsp_valid_o, rsp_error_o;
   logic [3:0]  rsp_rdata_o;
   logic        psel_o, penable_o, pwrite_o;
   logic [3:0]  paddr_o, pwdata_o, prdata_i;
   logic        pready_i, perror_i;
   logic        intp_valid_i;
   logic [3:0]  intp_to_service_i;
   logic        intp_serviced_o;
   logic [15:0] intp_clear_o;
   logic        busy_o;
   logic [7:0]  serviced_cnt_o;

   int checks = 0;
   int errors = 0;

   intp_apb_host dut (
      .pclk_i(clk), .prst_n_i(prst_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
      .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .perror_i(perror_i),
      .intp_valid_i(intp_valid_i), .intp_to_service_i(intp_to_service_i),
      .intp_serviced_o(intp_serviced_o), .intp_clear_o(intp_clear_o),
      .busy_o(busy_o), .serviced_cnt_o(serviced_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // waits < 0 means pready never asserts.
   task automatic apb(input logic w, input logic [3:0] a, input logic [3:0] d, input int waits,
                      input logic perr, input logic [3:0] rd, input int exp_acc,
                      input logic exp_err, input logic [3:0] exp_rdata);
      int  acc;
      logic got;
      check("cmd_ready_idle", cmd_ready_o, 1);
      cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d;
      tick();
      cmd_valid_i = 1'b0;
      cmd_addr_i = ~a;
      check("setup_sel_en", {psel_o, penable_o}, 2'b10);
      check("setup_addr", {pwrite_o, paddr_o}, {w, a});
      if (w) check("setup_wdata", pwdata_o, d);
      check("setup_not_ready", cmd_ready_o, 0);
      tick();
      acc = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         acc++;
         check("access_sel_en", {psel_o, penable_o, rsp_valid_o}, 3'b110);
         check("access_addr", paddr_o, a);
         pready_i = (waits >= 0 && acc == waits + 1);
         perror_i = perr && pready_i;
         prdata_i = rd;
         tick();
         pready_i = 1'b0; perror_i = 1'b0; prdata_i = 4'h0;
         if (rsp_valid_o) got = 1'b1;
      end
      check("rsp_seen", got, 1);
      check("access_cycles", acc, exp_acc);
      check("rsp_error", rsp_error_o, exp_err);
      check("rsp_rdata", rsp_rdata_o, exp_rdata);
      check("rsp_bus_idle", {psel_o, penable_o}, 2'b00);
      tick();
      check("rsp_pulse_end", rsp_valid_o, 0);
      check("rdata_held", rsp_rdata_o, exp_rdata);
      $display("apb w=%0d addr=%0h wdata=%0h acc=%0d err=%0d rdata=%0h", w, a, d, acc, rsp_error_o, rsp_rdata_o);
   endtask

   // hold = cycles intp_valid_i stays high after serviced is seen.
   task automatic svc(input logic [3:0] id, input logic [7:0] exp_cnt, input int hold);
      logic [15:0] exp_clr;
      exp_clr = 16'h0001 << id;
      intp_valid_i = 1'b1; intp_to_service_i = id;
      tick();
      check("svc_busy", busy_o, 1);
      intp_to_service_i = id ^ 4'hA;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("svc_window", intp_serviced_o, 0);
      end
      tick();
      check("serviced", intp_serviced_o, 1);
      check("clear", intp_clear_o, exp_clr);
      check("serviced_cnt", serviced_cnt_o, exp_cnt);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("stale_hold", {intp_serviced_o, busy_o}, 2'b01);
         check("stale_clear", intp_clear_o, 0);
      end
      intp_valid_i = 1'b0;
      tick();
      check("drop_no_pulse", {intp_serviced_o, intp_clear_o}, 0);
      tick();
      check("back_idle", busy_o, 0);
      check("cnt_stable", serviced_cnt_o, exp_cnt);
      if (exp_cnt < 8'd4 || exp_cnt == 8'd0)
         $display("svc id=%0d cnt=%0d hold=%0d", id, serviced_cnt_o, hold);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_apb"}, {cmd_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, psel_o, penable_o,
                            pwrite_o, paddr_o, pwdata_o}, 0);
      check({tag, "_intp"}, {intp_serviced_o, intp_clear_o, busy_o, serviced_cnt_o}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      prst_n_i = 1'b0;
      cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 4'h0; cmd_wdata_i = 4'h0;
      prdata_i = 4'h0; pready_i = 1'b0; perror_i = 1'b0;
      intp_valid_i = 1'b0; intp_to_service_i = 4'h0;
      repeat (3) tick();
      check_all_zero("reset_state");
      prst_n_i = 1'b1;
      tick();
      check("ready_after_reset", cmd_ready_o, 1);

      // APB transfers
      apb(1'b1, 4'h3, 4'h9, 0,  1'b0, 4'h0, 1, 1'b0, 4'h0);
      apb(1'b0, 4'h3, 4'h0, 2,  1'b0, 4'h9, 3, 1'b0, 4'h9);
      apb(1'b0, 4'h4, 4'h0, 1,  1'b0, 4'h6, 2, 1'b0, 4'h6);
      apb(1'b0, 4'h7, 4'h0, -1, 1'b0, 4'h5, 8, 1'b1, 4'h6);
      apb(1'b1, 4'h1, 4'hC, 0,  1'b1, 4'h3, 1, 1'b1, 4'h6);

      // Interrupt servicing, stale valid held 3 cycles, then immediate new request
      svc(4'd5, 8'd1, 3);
      svc(4'd2, 8'd2, 0);

      // Reset in the middle of ACCESS and SERVICE
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h8;
      intp_valid_i = 1'b1; intp_to_service_i = 4'd7;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      check("mid_access", {psel_o, penable_o, busy_o}, 3'b111);
      intp_valid_i = 1'b0;
      prst_n_i = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick();
      prst_n_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("post_reset_quiet", {rsp_valid_o, intp_serviced_o, busy_o, psel_o}, 0);
      end
      $display("reset mid-operation: cnt=%0d busy=%0d", serviced_cnt_o, busy_o);

      // 256 services wrap the counter back to zero
      for (int i = 1; i <= 256; i++)
         svc(4'(i), 8'(i), 0);
      check("cnt_wrap", serviced_cnt_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
